// File: rtl/c64_kbd_pkg.sv
// Shared types, PS/2 constants and the PC scancode to C64 matrix map.
package c64_kbd_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ERR    = 8'hFF;

    typedef struct packed {
        logic       valid;
        logic       restore;
        logic [2:0] col;
        logic [2:0] row;
    } key_map_t;

    // Matrix position written as two octal digits: {col, row}.
    function automatic key_map_t key_at(input logic [5:0] cr);
        key_map_t m;
        m.valid   = 1'b1;
        m.restore = 1'b0;
        m.col     = cr[5:3];
        m.row     = cr[2:0];
        return m;
    endfunction

    // Lookup keyed by {E0 prefix seen, scancode}; misses return valid=0.
    function automatic key_map_t kbd_lookup(input logic ext, input logic [7:0] code);
        key_map_t m;
        m = '0;
        case ({ext, code})
            // col0: DEL RETURN CRSR-LR F7 F1 F3 F5 CRSR-UD
            9'h066: m = key_at(6'o00);  9'h05A: m = key_at(6'o01);  9'h174: m = key_at(6'o02);
            9'h083: m = key_at(6'o03);  9'h005: m = key_at(6'o04);  9'h004: m = key_at(6'o05);
            9'h003: m = key_at(6'o06);  9'h172: m = key_at(6'o07);
            // col1: 3 W A 4 Z S E LSHIFT
            9'h026: m = key_at(6'o10);  9'h01D: m = key_at(6'o11);  9'h01C: m = key_at(6'o12);
            9'h025: m = key_at(6'o13);  9'h01A: m = key_at(6'o14);  9'h01B: m = key_at(6'o15);
            9'h024: m = key_at(6'o16);  9'h012: m = key_at(6'o17);
            // col2: 5 R D 6 C F T X
            9'h02E: m = key_at(6'o20);  9'h02D: m = key_at(6'o21);  9'h023: m = key_at(6'o22);
            9'h036: m = key_at(6'o23);  9'h021: m = key_at(6'o24);  9'h02B: m = key_at(6'o25);
            9'h02C: m = key_at(6'o26);  9'h022: m = key_at(6'o27);
            // col3: 7 Y G 8 B H U V
            9'h03D: m = key_at(6'o30);  9'h035: m = key_at(6'o31);  9'h034: m = key_at(6'o32);
            9'h03E: m = key_at(6'o33);  9'h032: m = key_at(6'o34);  9'h033: m = key_at(6'o35);
            9'h03C: m = key_at(6'o36);  9'h02A: m = key_at(6'o37);
            // col4: 9 I J 0 M K O N
            9'h046: m = key_at(6'o40);  9'h043: m = key_at(6'o41);  9'h03B: m = key_at(6'o42);
            9'h045: m = key_at(6'o43);  9'h03A: m = key_at(6'o44);  9'h042: m = key_at(6'o45);
            9'h044: m = key_at(6'o46);  9'h031: m = key_at(6'o47);
            // col5: + P L - . : @ ,   (keypad+, P, L, -, ., ', [, ,)
            9'h079: m = key_at(6'o50);  9'h04D: m = key_at(6'o51);  9'h04B: m = key_at(6'o52);
            9'h04E: m = key_at(6'o53);  9'h049: m = key_at(6'o54);  9'h052: m = key_at(6'o55);
            9'h054: m = key_at(6'o56);  9'h041: m = key_at(6'o57);
            // col6: pound * ; HOME RSHIFT = / (backslash, ], ;, E0-home, rshift, =, /)
            9'h05D: m = key_at(6'o60);  9'h05B: m = key_at(6'o61);  9'h04C: m = key_at(6'o62);
            9'h16C: m = key_at(6'o63);  9'h059: m = key_at(6'o64);  9'h055: m = key_at(6'o65);
            9'h04A: m = key_at(6'o67);
            // col7: 1 <- CTRL 2 SPACE C= Q RUN/STOP
            9'h016: m = key_at(6'o70);  9'h00E: m = key_at(6'o71);  9'h014: m = key_at(6'o72);
            9'h01E: m = key_at(6'o73);  9'h029: m = key_at(6'o74);  9'h011: m = key_at(6'o75);
            9'h015: m = key_at(6'o76);  9'h076: m = key_at(6'o77);
            // PgUp drives RESTORE, which sits outside the matrix
            9'h17D: begin m.valid = 1'b1; m.restore = 1'b1; end
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/c64_keyboard_if.sv
// CIA1 port A/B bus between the CIA model and the keyboard matrix.
interface c64_keyboard_if;
    logic [7:0] pa_out;
    logic [7:0] pb_out;
    logic [7:0] pa_in;
    logic [7:0] pb_in;

    modport master (output pa_out, output pb_out, input pa_in, input pb_in);
    modport slave  (input pa_out, input pb_out, output pa_in, output pb_in);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: sync, glitch filter, frame FSM, timeout.
module ps2_rx
    import c64_kbd_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 65535
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       err
);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    // index 0 = ps2_clk, index 1 = ps2_dat
    logic [1:0]         sync1_q, sync1_d, sync2_q, sync2_d, lvl_q, lvl_d;
    logic [1:0][FW-1:0] cnt_q, cnt_d;
    logic               clk_prev_q, clk_prev_d, fall;
    rx_state_t          state_q, state_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               par_q, par_d, byte_vld_q, byte_vld_d, err_q, err_d;
    logic [TW-1:0]      tmo_q, tmo_d;

    // Synchronize, then accept a new level only after FILTER_LEN stable clocks
    always_comb begin
        sync1_d    = {ps2_dat, ps2_clk};
        sync2_d    = sync1_q;
        lvl_d      = lvl_q;
        cnt_d      = cnt_q;
        clk_prev_d = lvl_q[0];
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == lvl_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == FW'(FILTER_LEN - 1)) begin
                lvl_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + FW'(1);
            end
        end
    end

    assign fall = clk_prev_q & ~lvl_q[0];

    // Frame FSM: bits sampled on filtered falling edges; stalls abort via timeout
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tmo_d      = '0;
        byte_vld_d = 1'b0;
        err_d      = 1'b0;
        if (fall) begin
            case (state_q)
                IDLE: begin
                    if (lvl_q[1]) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {lvl_q[1], shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = lvl_q[1];
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (lvl_q[1] && (^{shift_q, par_q})) byte_vld_d = 1'b1;
                    else                                  err_d      = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (tmo_q == TW'(TIMEOUT - 1)) begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                err_d     = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    // State registers; lines reset to the idle-high level so no edge is invented
    always_ff @(posedge clk) begin
        if (!res_n) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            lvl_q      <= 2'b11;
            cnt_q      <= '0;
            clk_prev_q <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            byte_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            lvl_q      <= lvl_d;
            cnt_q      <= cnt_d;
            clk_prev_q <= clk_prev_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            byte_vld_q <= byte_vld_d;
            err_q      <= err_d;
        end
    end

    assign rx_byte  = shift_q;
    assign byte_vld = byte_vld_q;
    assign err      = err_q;

endmodule

// File: rtl/c64_keyboard.sv
// PS/2 keyboard to C64 CIA1 matrix: scancode decoder, key matrix, port logic.
module c64_keyboard
    import c64_kbd_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 65535
) (
    input  logic           clk,
    input  logic           res_n,
    input  logic           ps2_clk,
    input  logic           ps2_dat,
    c64_keyboard_if.slave  cia,
    output logic           restore_n,
    output logic           rx_err
);
    logic [7:0]      rx_byte;
    logic            rx_vld;
    key_map_t        map;
    logic [7:0][7:0] key_q, key_d;   // key[col][row]
    logic            ext_q, ext_d, brk_q, brk_d, restore_q, restore_d;
    logic [7:0]      pa_in_q, pa_in_d, pb_in_q, pb_in_d;

    ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) u_rx (
        .clk      (clk),
        .res_n    (res_n),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .rx_byte  (rx_byte),
        .byte_vld (rx_vld),
        .err      (rx_err)
    );

    assign map = kbd_lookup(ext_q, rx_byte);

    // Decoder: prefixes set flags, any other byte consumes them
    always_comb begin
        key_d     = key_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        restore_d = restore_q;
        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_vld) begin
            if (rx_byte == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (rx_byte == PS2_BAT_OK || rx_byte == PS2_ERR) begin
                    key_d     = '0;
                    restore_d = 1'b0;
                end else if (map.valid) begin
                    if (map.restore) restore_d = ~brk_q;
                    else             key_d[map.col][map.row] = ~brk_q;
                end
            end
        end
    end

    // Matrix scan: a held key pulls a line low when its crossing line is driven low
    always_comb begin
        pa_in_d = cia.pa_out;
        pb_in_d = cia.pb_out;
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) begin
                if (key_q[c][r] && !cia.pa_out[c]) pb_in_d[r] = 1'b0;
                if (key_q[c][r] && !cia.pb_out[r]) pa_in_d[c] = 1'b0;
            end
        end
    end

    // Decoder state and registered port read-back
    always_ff @(posedge clk) begin
        if (!res_n) begin
            key_q     <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            restore_q <= 1'b0;
            pa_in_q   <= 8'hFF;
            pb_in_q   <= 8'hFF;
        end else begin
            key_q     <= key_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            restore_q <= restore_d;
            pa_in_q   <= pa_in_d;
            pb_in_q   <= pb_in_d;
        end
    end

    assign cia.pa_in = pa_in_q;
    assign cia.pb_in = pb_in_q;
    assign restore_n = ~restore_q;

endmodule

// File: tb/tb_c64_keyboard.sv
// Scoreboard bench: a key-matrix model predicts port read-backs per probe.
module tb_c64_keyboard;
    localparam int FLT  = 4;
    localparam int TMO  = 400;
    localparam int HALF = 30;

    logic clk = 1'b0, res_n = 1'b0, ps2_clk = 1'b1, ps2_dat = 1'b1;
    logic restore_n, rx_err;

    c64_keyboard_if cia();

    c64_keyboard #(.FILTER_LEN(FLT), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .res_n     (res_n),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .cia       (cia),
        .restore_n (restore_n),
        .rx_err    (rx_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pa, pb, epa, epb;
        logic       ers;
    } probe_t;

    int         n_chk = 0, n_err = 0, err_seen = 0, err_base = 0;
    logic [7:0] mk [8];   // model matrix mk[col][row]
    logic       mrest;
    probe_t     sb[$];
    string      sb_tag[$];

    always @(negedge clk) if (res_n && rx_err) err_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_dat = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad = 1'b0);
        logic [10:0] f;
        f = {1'b1, (~^code) ^ bad, code, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(f[i]);
        tick(4 * HALF);
    endtask

    function automatic bit tb_pos(input logic [7:0] code, output int c, output int r);
        tb_pos = 1'b1;
        case (code)
            8'h1C: begin c = 1; r = 2; end
            8'h29: begin c = 7; r = 4; end
            8'h5A: begin c = 0; r = 1; end
            8'h12: begin c = 1; r = 7; end
            8'h59: begin c = 6; r = 4; end
            8'h76: begin c = 7; r = 7; end
            default: begin c = 0; r = 0; tb_pos = 1'b0; end
        endcase
    endfunction

    task automatic model_set(input logic [7:0] code, input logic v);
        int c, r;
        if (tb_pos(code, c, r)) mk[c][r] = v;
    endtask

    task automatic model_clear();
        for (int c = 0; c < 8; c++) mk[c] = '0;
        mrest = 1'b0;
    endtask

    task automatic make_key(input logic [7:0] code);
        send_frame(code);
        model_set(code, 1'b1);
    endtask

    task automatic break_key(input logic [7:0] code);
        send_frame(8'hF0);
        send_frame(code);
        model_set(code, 1'b0);
    endtask

    function automatic logic [7:0] exp_pb(input logic [7:0] pa, input logic [7:0] pb);
        exp_pb = pb;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (mk[c][r] && !pa[c]) exp_pb[r] = 1'b0;
    endfunction

    function automatic logic [7:0] exp_pa(input logic [7:0] pa, input logic [7:0] pb);
        exp_pa = pa;
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 8; r++)
                if (mk[c][r] && !pb[r]) exp_pa[c] = 1'b0;
    endfunction

    task automatic push(input string tag, input logic [7:0] pa, input logic [7:0] pb);
        probe_t p;
        p = '{pa, pb, exp_pa(pa, pb), exp_pb(pa, pb), ~mrest};
        sb.push_back(p);
        sb_tag.push_back(tag);
    endtask

    task automatic push_rand(input string tag, input int n);
        for (int i = 0; i < n; i++)
            push(tag, 8'($urandom), 8'($urandom));
    endtask

    task automatic drain();
        probe_t p;
        string  t;
        while (sb.size() > 0) begin
            p = sb.pop_front();
            t = sb_tag.pop_front();
            cia.pa_out = p.pa;
            cia.pb_out = p.pb;
            tick(1);
            chk({t, "_pb"}, {24'd0, cia.pb_in}, {24'd0, p.epb});
            chk({t, "_pa"}, {24'd0, cia.pa_in}, {24'd0, p.epa});
            chk({t, "_rst_n"}, {31'd0, restore_n}, {31'd0, p.ers});
        end
        cia.pa_out = 8'hFF;
        cia.pb_out = 8'hFF;
    endtask

    task automatic chk_err(input string tag, input int exp);
        chk(tag, err_seen - err_base, exp);
        err_base = err_seen;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        cia.pa_out = 8'h00;
        cia.pb_out = 8'h00;
        res_n = 1'b0;
        tick(4);
        chk("rst_pa_in", {24'd0, cia.pa_in}, 32'hFF);
        chk("rst_pb_in", {24'd0, cia.pb_in}, 32'hFF);
        chk("rst_restore_n", {31'd0, restore_n}, 32'd1);
        chk("rst_rx_err", {31'd0, rx_err}, 32'd0);
        res_n = 1'b1;
        cia.pa_out = 8'hFF;
        cia.pb_out = 8'hFF;
        tick(2 * HALF);
        err_base = err_seen;

        // single make, then break
        make_key(8'h1C);
        push("mkA_sel", 8'hFD, 8'hFF); push("mkA_nosel", 8'hFF, 8'hFF); drain();
        chk_err("mkA_err", 0);
        break_key(8'h1C);
        push("brkA", 8'hFD, 8'hFF); drain();
        chk_err("brkA_err", 0);

        // two keys, forward and reverse scan
        make_key(8'h1C);
        make_key(8'h29);
        push("two_fwd", 8'h7D, 8'hFF); push("two_rev", 8'hFF, 8'hFB);
        push_rand("two_rnd", 3); drain();
        chk_err("two_err", 0);

        // self-test pass clears the matrix
        send_frame(8'hAA);
        model_clear();
        push("aa_rows", 8'h00, 8'hFF); push("aa_cols", 8'hFF, 8'h00); drain();

        // bad parity dropped, following frame accepted
        send_frame(8'h1C, 1'b1);
        chk_err("par_err", 1);
        push("par_drop", 8'hFD, 8'hFF); drain();
        make_key(8'h29);
        push("par_next", 8'h7F, 8'hFF); drain();

        // repeated make and break of an unheld key change nothing
        make_key(8'h29);
        break_key(8'h1C);
        push("rep_sp", 8'h7F, 8'hFF); push_rand("rep_rnd", 2); drain();
        chk_err("rep_err", 0);

        // E0 1C is unmapped
        send_frame(8'hE0);
        send_frame(8'h1C);
        push("ext_unmap", 8'hFD, 8'hFF); drain();

        // start bit of 1
        send_bit(1'b1);
        tick(4 * HALF);
        chk_err("start_err", 1);

        // timeout after 4 bits, then a good frame
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        tick(TMO + 100);
        chk_err("tmo_err", 1);
        make_key(8'h5A);
        push("tmo_next", 8'hFE, 8'hFF); drain();
        chk_err("tmo_next_err", 0);

        // RESTORE
        send_frame(8'hE0); send_frame(8'h7D);
        mrest = 1'b1;
        push("rest_on", 8'hFF, 8'hFF); drain();
        send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h7D);
        mrest = 1'b0;
        push("rest_off", 8'hFF, 8'hFF); drain();

        // several keys at once
        make_key(8'h12); make_key(8'h59); make_key(8'h76);
        push("multi_all", 8'h00, 8'hFF); push_rand("multi_rnd", 3); drain();
        chk_err("multi_err", 0);

        // reset mid-frame with keys and RESTORE held
        send_frame(8'hE0); send_frame(8'h7D);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        cia.pa_out = 8'h00;
        cia.pb_out = 8'h00;
        res_n = 1'b0;
        tick(3);
        chk("mid_rst_pa_in", {24'd0, cia.pa_in}, 32'hFF);
        chk("mid_rst_pb_in", {24'd0, cia.pb_in}, 32'hFF);
        chk("mid_rst_restore_n", {31'd0, restore_n}, 32'd1);
        chk("mid_rst_rx_err", {31'd0, rx_err}, 32'd0);
        res_n = 1'b1;
        cia.pa_out = 8'hFF;
        cia.pb_out = 8'hFF;
        model_clear();
        tick(2 * HALF);
        err_base = err_seen;
        make_key(8'h76);
        push("post_rst_esc", 8'h7F, 8'hFF); push("post_rst_all", 8'h00, 8'hFF); drain();
        chk_err("post_rst_err", 0);

        // FF also clears
        make_key(8'h1C);
        send_frame(8'hFF);
        model_clear();
        push("ff_clr", 8'h00, 8'hFF); drain();
        chk_err("ff_err", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
